// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit common-anode seven-segment scanner with guard cycle
// and a load/ready handshake that commits new values only at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIV = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic        ready,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic [3:0]  an
);
  // abcdefg, active-low, indexed by hex digit
  localparam logic [15:0][6:0] SEG = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  logic [15:0] p_q, p_d, pv_q, pv_d, dv_q, dv_d;
  logic [1:0]  idx_q, idx_d;
  logic        pend_q, pend_d, dp_q, dp_d;
  logic [3:0]  pb_q, pb_d, pd_q, pd_d, db_q, db_d, dd_q, dd_d, an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        wrap, commit, accept, drive, lit;
  logic [3:0]  digit;
  always_comb begin
    wrap   = p_q == 16'(DIV - 1);
    commit = en && wrap && idx_q == 2'd3 && pend_q;
    accept = load && !pend_q;
    p_d    = (!en || wrap) ? '0 : p_q + 16'd1;
    idx_d  = !en ? 2'd0 : wrap ? idx_q + 2'd1 : idx_q;
    pend_d = accept || (pend_q && !commit);
    pv_d   = accept ? value : pv_q;
    pb_d   = accept ? blank : pb_q;
    pd_d   = accept ? dp_in : pd_q;
    dv_d   = commit ? pv_q : dv_q;
    db_d   = commit ? pb_q : db_q;
    dd_d   = commit ? pd_q : dd_q;
    // p=0 is the anti-ghosting guard: anodes off before switching digits
    drive  = en && p_q != '0;
    lit    = drive && !db_q[idx_q];
    digit  = dv_q[{idx_q, 2'b00} +: 4];
    an_d   = drive ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d  = lit ? SEG[digit] : 7'h7F;
    dp_d   = !(lit && dd_q[idx_q]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q    <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      pv_q   <= '0;
      pb_q   <= '0;
      pd_q   <= '0;
      dv_q   <= '0;
      db_q   <= 4'hF;
      dd_q   <= '0;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      p_q    <= p_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      pb_q   <= pb_d;
      pd_q   <= pd_d;
      dv_q   <= dv_d;
      db_q   <= db_d;
      dd_q   <= dd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end
  assign ready = !pend_q;
  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp = dp_q;
  assign an = an_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed checks of seg_scan_ctrl against a
// time-position reference model (scan position = en-cycles since last stop).
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic clk = 0, reset_n = 0, en = 0, load = 0;
  logic [15:0] value = '0;
  logic [3:0] blank = '0, dp_in = '0;
  logic ready, a, b, c, d, e, f, g, dp;
  logic [3:0] an;
  int checks = 0, errors = 0;
  int t;
  bit m_pend;
  logic [15:0] m_pv, m_dv;
  logic [3:0] m_pb, m_pd, m_db, m_dd, e_an;
  logic [6:0] e_seg;
  logic e_dp;

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .value(value),
    .blank(blank), .dp_in(dp_in), .ready(ready), .a(a), .b(b), .c(c),
    .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".an"}, 32'(an), 32'(e_an));
    check({tag, ".seg"}, 32'({a, b, c, d, e, f, g}), 32'(e_seg));
    check({tag, ".dp"}, 32'(dp), 32'(e_dp));
    check({tag, ".ready"}, 32'(ready), 32'(!m_pend));
  endtask

  task automatic m_reset();
    t = 0; m_pend = 0; m_pv = '0; m_pb = '0; m_pd = '0;
    m_dv = '0; m_db = 4'hF; m_dd = '0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
  endtask

  // Predict the next registered outputs from the scan position, then advance.
  task automatic cyc(input string tag);
    int slot_pos, k;
    bit pend_old;
    slot_pos = t % DIV;
    k = t / DIV;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (en && slot_pos != 0) begin
      e_an[k] = 1'b0;
      if (!m_db[k]) begin
        e_seg = HEX[m_dv[4*k +: 4]];
        e_dp = !m_dd[k];
      end
    end
    pend_old = m_pend;
    if (en && t == FR - 1 && pend_old) begin
      m_dv = m_pv; m_db = m_pb; m_dd = m_pd; m_pend = 0;
    end
    if (load && !pend_old) begin
      m_pv = value; m_pb = blank; m_pd = dp_in; m_pend = 1;
    end
    t = en ? (t + 1) % FR : 0;
    @(posedge clk); #1;
    check_outs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic post(input string tag, input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dpi);
    int w;
    w = 0;
    while (m_pend && w < 2 * FR) begin cyc(tag); w++; end
    check({tag, ".ready_wait"}, 32'(m_pend), 32'(0));
    value = v; blank = bl; dp_in = dpi; load = 1;
    cyc(tag);
    load = 0;
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < 6; i++) begin
      load = i[0]; en = i[1];
      @(posedge clk); #1;
      check_outs("reset_hold");
    end
    load = 0; en = 1; reset_n = 1;
    run("dark_scan", 2 * FR);
    post("basic", 16'h4275, 4'h0, 4'h0);
    run("basic", 3 * FR);
    post("hs1", 16'h1111, 4'h0, 4'h0);
    value = 16'h2222; load = 1;
    cyc("hs2");
    load = 0;
    run("hs", 3 * FR);
    for (int i = 0; i < FR && t != FR - 1; i++) cyc("align");
    check("align_boundary", 32'(t), 32'(FR - 1));
    value = 16'h8888; blank = 0; dp_in = 0; load = 1;
    cyc("collide");
    load = 0;
    run("collide", 3 * FR);
    post("sw0", 16'h0123, 4'b0100, 4'b0001); run("sw0", 2 * FR);
    post("sw1", 16'h4567, 4'b0100, 4'b0001); run("sw1", 2 * FR);
    post("sw2", 16'h89AB, 4'b0100, 4'b0001); run("sw2", 2 * FR);
    post("sw3", 16'hCDEF, 4'b0100, 4'b0001); run("sw3", 2 * FR);
    post("sw4", 16'hD951, 4'b0000, 4'b1010); run("sw4", 2 * FR);
    post("dis", 16'h3A3A, 4'h0, 4'h0);
    run("dis", 2);
    en = 0;
    run("en_off", 2 * FR);
    en = 1;
    run("en_on", 3 * FR);
    post("rst", 16'h5B5B, 4'h0, 4'h0);
    run("rst", 3);
    #2 reset_n = 0;
    #1 m_reset();
    check_outs("async_rst");
    @(posedge clk); #1;
    check_outs("rst_hold");
    reset_n = 1;
    run("after_rst", 2 * FR);
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 9) != 0;
      load = $urandom_range(0, 4) == 0;
      value = 16'($urandom);
      blank = 4'($urandom);
      dp_in = 4'($urandom);
      cyc("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
